// File: rtl/mdio_responder.sv
// Clause 22 MDIO register responder: paged 32x16 register banks with a page-select
// register, sampled from a synchronized mdc in the clk domain.
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR = 5'd0,
    parameter int         PAGES    = 4,
    parameter logic [4:0] PAGE_REG = 5'd22,
    parameter int         TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    inout  wire         mdio,
    output logic        wr_valid,
    output logic [7:0]  wr_page,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data
);
    localparam int NREG = PAGES * 32;
    localparam int IDXW = $clog2(NREG);
    localparam int TOW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, ST1, HDR, RD_TA, RD_DATA, WR_TA, WR_DATA, SKIP
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      mdc_sync_q, mdc_sync_d;
    logic [1:0]      mdio_sync_q, mdio_sync_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [11:0]     hdr_q, hdr_d;
    logic            ta_q, ta_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [15:0]     rd_sh_q, rd_sh_d;
    logic [7:0]      page_q, page_d;
    logic            mdio_oe_q, mdio_oe_d;
    logic            mdio_out_q, mdio_out_d;
    logic [TOW-1:0]  to_cnt_q, to_cnt_d;
    logic            commit_q, commit_d;
    logic            wr_valid_q, wr_valid_d;
    logic [7:0]      wr_page_q, wr_page_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [15:0]     wr_data_q, wr_data_d;
    logic [15:0]     regs_q [NREG];

    logic            mdc_rise, mdc_fall, bit_in;
    logic [11:0]     hdr_next;
    logic [15:0]     wdata_next;
    logic [4:0]      regad;
    logic            page_ok;
    logic [IDXW-1:0] reg_idx;
    logic [15:0]     rd_word;
    logic            reg_we;

    assign mdc_rise   = mdc_sync_q[1] & ~mdc_sync_q[2];
    assign mdc_fall   = ~mdc_sync_q[1] & mdc_sync_q[2];
    assign bit_in     = mdio_sync_q[1];
    assign hdr_next   = {hdr_q[10:0], bit_in};
    assign wdata_next = {wdata_q[14:0], bit_in};
    assign regad      = hdr_q[4:0];
    assign page_ok    = int'(page_q) < PAGES;
    // Only meaningful when page_ok, where {page, regad} always fits the index width.
    assign reg_idx    = IDXW'({page_q, regad});

    assign mdio     = mdio_oe_q ? mdio_out_q : 1'bz;
    assign wr_valid = wr_valid_q;
    assign wr_page  = wr_page_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    always_comb begin
        rd_word = 16'h0;
        if (regad == PAGE_REG) begin
            rd_word = {8'h00, page_q};
        end else if (page_ok) begin
            rd_word = regs_q[reg_idx];
        end
    end

    always_comb begin
        mdc_sync_d  = {mdc_sync_q[1:0], mdc};
        mdio_sync_d = {mdio_sync_q[0], mdio};
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        ta_d        = ta_q;
        wdata_d     = wdata_q;
        rd_sh_d     = rd_sh_q;
        page_d      = page_q;
        mdio_oe_d   = mdio_oe_q;
        mdio_out_d  = mdio_out_q;
        commit_d    = 1'b0;
        wr_valid_d  = commit_q;
        wr_page_d   = wr_page_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we      = 1'b0;
        to_cnt_d    = (state_q == IDLE || mdc_rise) ? '0 : to_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                mdio_oe_d = 1'b0;
                if (mdc_rise && !bit_in) state_d = ST1;
            end
            ST1: begin
                if (mdc_rise) begin
                    cnt_d   = '0;
                    state_d = bit_in ? HDR : IDLE;
                end
            end
            HDR: begin
                if (mdc_rise) begin
                    hdr_d = hdr_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd11) begin
                        cnt_d = '0;
                        if (hdr_next[9:5] == PHY_ADDR && hdr_next[11:10] == 2'b10) begin
                            state_d = RD_TA;
                        end else if (hdr_next[9:5] == PHY_ADDR && hdr_next[11:10] == 2'b01) begin
                            state_d = WR_TA;
                        end else begin
                            state_d = SKIP;
                        end
                    end
                end
            end
            RD_TA: begin
                // First fall opens TA bit 1 (left released), second fall opens TA bit 2.
                if (mdc_fall) begin
                    if (cnt_q == 5'd0) begin
                        cnt_d = 5'd1;
                    end else begin
                        mdio_oe_d  = 1'b1;
                        mdio_out_d = 1'b0;
                        rd_sh_d    = rd_word;
                        cnt_d      = '0;
                        state_d    = RD_DATA;
                    end
                end
            end
            RD_DATA: begin
                if (mdc_fall) begin
                    if (cnt_q == 5'd16) begin
                        mdio_oe_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        mdio_out_d = rd_sh_q[15];
                        rd_sh_d    = {rd_sh_q[14:0], 1'b0};
                        cnt_d      = cnt_q + 5'd1;
                    end
                end
            end
            WR_TA: begin
                if (mdc_rise) begin
                    if (cnt_q == 5'd0) begin
                        ta_d  = bit_in;
                        cnt_d = 5'd1;
                    end else if ({ta_q, bit_in} == 2'b10) begin
                        cnt_d   = '0;
                        state_d = WR_DATA;
                    end else begin
                        cnt_d   = 5'd2;
                        state_d = SKIP;
                    end
                end
            end
            WR_DATA: begin
                if (mdc_rise) begin
                    wdata_d = wdata_next;
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        cnt_d     = '0;
                        state_d   = IDLE;
                        commit_d  = 1'b1;
                        wr_page_d = page_q;
                        wr_addr_d = regad;
                        wr_data_d = wdata_next;
                        if (regad == PAGE_REG) begin
                            page_d = wdata_next[7:0];
                        end else begin
                            reg_we = page_ok;
                        end
                    end
                end
            end
            SKIP: begin
                if (mdc_rise) begin
                    if (cnt_q == 5'd17) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled station abandons the frame and frees the line.
        if (state_q != IDLE && !mdc_rise && to_cnt_q == TOW'(TIMEOUT - 1)) begin
            state_d   = IDLE;
            mdio_oe_d = 1'b0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mdc_sync_q  <= '0;
            mdio_sync_q <= '0;
            cnt_q       <= '0;
            hdr_q       <= '0;
            ta_q        <= 1'b0;
            wdata_q     <= '0;
            rd_sh_q     <= '0;
            page_q      <= '0;
            mdio_oe_q   <= 1'b0;
            mdio_out_q  <= 1'b0;
            to_cnt_q    <= '0;
            commit_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_page_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            mdc_sync_q  <= mdc_sync_d;
            mdio_sync_q <= mdio_sync_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            ta_q        <= ta_d;
            wdata_q     <= wdata_d;
            rd_sh_q     <= rd_sh_d;
            page_q      <= page_d;
            mdio_oe_q   <= mdio_oe_d;
            mdio_out_q  <= mdio_out_d;
            to_cnt_q    <= to_cnt_d;
            commit_q    <= commit_d;
            wr_valid_q  <= wr_valid_d;
            wr_page_q   <= wr_page_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[reg_idx] <= wdata_next;
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: a bit-level MDIO station, a register/page model
// of the responder, and a per-cycle monitor that scores wr_valid pulses and line quiet.
module tb_mdio_responder;
    localparam logic [4:0] PHY = 5'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdc;
    logic        sta_oe;
    logic        sta_out;
    wire         mdio;
    logic        wr_valid;
    logic [7:0]  wr_page;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [28:0] exp_q[$];
    logic [15:0] m_regs [0:3][0:31];
    logic [7:0]  m_page;
    logic        exp_quiet = 1'b0;
    logic        prev_wv   = 1'b0;
    logic [15:0] got;

    assign mdio = sta_oe ? sta_out : 1'bz;

    always #5 clk = ~clk;

    mdio_responder #(
        .PHY_ADDR(PHY), .PAGES(4), .PAGE_REG(5'd22), .TIMEOUT(1024)
    ) dut (
        .clk(clk), .rst(rst), .mdc(mdc), .mdio(mdio),
        .wr_valid(wr_valid), .wr_page(wr_page), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [4:0] ra);
        if (ra == 5'd22) return {8'h00, m_page};
        if (m_page < 8'd4) return m_regs[m_page[1:0]][ra];
        return 16'h0000;
    endfunction

    task automatic model_reset();
        m_page = 8'h00;
        for (int p = 0; p < 4; p++)
            for (int r = 0; r < 32; r++) m_regs[p][r] = 16'h0000;
    endtask

    // Monitor: every wr_valid cycle must match the next expected commit and be 1 clk wide.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got page=%0d addr=%0d data=%h, none expected",
                             wr_page, wr_addr, wr_data);
                end else begin
                    check("wr_fields", 32'({wr_page, wr_addr, wr_data}), 32'(exp_q.pop_front()));
                end
                check("wr_pulse_width", 32'(prev_wv), 32'd0);
            end
            if (exp_quiet) check("quiet_oe", 32'(dut.mdio_oe_q), 32'd0);
        end
        prev_wv = wr_valid;
    end

    // One mdc period: fall, station drives (or releases), wait, sample, rise.
    task automatic mbit(input logic drv, input logic val, output logic smp, output logic oe_s);
        mdc = 1'b0;
        sta_oe = drv;
        sta_out = val;
        #80;
        smp = mdio;
        oe_s = dut.mdio_oe_q;
        mdc = 1'b1;
        #80;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic s, o;
        for (int i = n - 1; i >= 0; i--) mbit(1'b1, v[i], s, o);
    endtask

    task automatic preamble(input int n);
        logic s, o;
        repeat (n) mbit(1'b1, 1'b1, s, o);
    endtask

    task automatic mdio_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d,
                              input logic [1:0] ta, input int pre);
        if (phy == PHY && ta == 2'b10) begin
            exp_q.push_back({m_page, ra, d});
            if (ra == 5'd22) m_page = d[7:0];
            else if (m_page < 8'd4) m_regs[m_page[1:0]][ra] = d;
        end
        preamble(pre);
        send_bits({2'b01, 2'b01, phy, ra, ta, d}, 32);
    endtask

    task automatic mdio_read(input logic [4:0] phy, input logic [4:0] ra, input int pre,
                             input int abort_at, output logic [15:0] data);
        logic s, o, matched, aborted;
        logic [15:0] exp_w;
        matched = (phy == PHY);
        exp_w = model_read(ra);
        aborted = 1'b0;
        data = 16'h0000;
        preamble(pre);
        exp_quiet = !matched;
        send_bits({18'h0, 2'b01, 2'b10, phy, ra}, 14);
        mbit(1'b0, 1'b0, s, o);
        check("rd_ta1_oe", 32'(o), 32'd0);
        mbit(1'b0, 1'b0, s, o);
        check("rd_ta2_oe", 32'(o), 32'(matched));
        if (matched) check("rd_ta2_line", 32'(s), 32'd0);
        for (int i = 15; i >= 0; i--) begin
            if (aborted) begin
                mbit(1'b1, 1'b1, s, o);
            end else if (i == abort_at) begin
                mdc = 1'b0;
                sta_oe = 1'b0;
                #60;
                check("abort_pre_oe", 32'(dut.mdio_oe_q), 32'd1);
                rst = 1'b1;
                #1;
                check("abort_oe", 32'(dut.mdio_oe_q), 32'd0);
                check("abort_wr_data", 32'(wr_data), 32'd0);
                check("abort_wr_page", 32'(wr_page), 32'd0);
                #19;
                rst = 1'b0;
                model_reset();
                sta_oe = 1'b1;
                sta_out = 1'b1;
                mdc = 1'b1;
                #80;
                aborted = 1'b1;
            end else begin
                mbit(1'b0, 1'b0, s, o);
                data[i] = s;
                check("rd_data_oe", 32'(o), 32'(matched));
                if (matched) check("rd_data_bit", 32'(s), 32'(exp_w[i]));
            end
        end
        mbit(1'b1, 1'b1, s, o);
        check("rd_release_oe", 32'(o), 32'd0);
        exp_quiet = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mdc = 1'b0;
        sta_oe = 1'b1;
        sta_out = 1'b1;
        model_reset();
        #3;
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_page", 32'(wr_page), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_oe", 32'(dut.mdio_oe_q), 32'd0);
        #19;
        rst = 1'b0;
        #160;

        mdio_read(PHY, 5'd24, 32, -1, got);
        check("rst_reg24", 32'(got), 32'h0000);

        // Page-select write, then read it back.
        mdio_write(PHY, 5'd22, 16'h0002, 2'b10, 32);
        mdio_read(PHY, 5'd22, 0, -1, got);
        check("page_reg_rd", 32'(got), 32'h0002);

        // Page 2 storage vs page 0 storage.
        mdio_write(PHY, 5'd24, 16'h2000, 2'b10, 2);
        mdio_read(PHY, 5'd24, 2, -1, got);
        check("p2_reg24", 32'(got), 32'h2000);
        mdio_write(PHY, 5'd22, 16'h0000, 2'b10, 2);
        mdio_read(PHY, 5'd24, 2, -1, got);
        check("p0_reg24_empty", 32'(got), 32'h0000);

        // Back-to-back frames with no preamble; boundary addresses 0 and 31.
        mdio_write(PHY, 5'd3, 16'hA5C3, 2'b10, 0);
        mdio_read(PHY, 5'd3, 0, -1, got);
        check("b2b_reg3", 32'(got), 32'hA5C3);
        mdio_write(PHY, 5'd31, 16'hFFFF, 2'b10, 1);
        mdio_write(PHY, 5'd0, 16'h1234, 2'b10, 0);
        mdio_write(PHY, 5'd24, 16'h1357, 2'b10, 0);
        mdio_read(PHY, 5'd31, 0, -1, got);
        check("reg31", 32'(got), 32'hFFFF);
        mdio_read(PHY, 5'd0, 0, -1, got);
        check("reg0", 32'(got), 32'h1234);

        // Foreign PHY address: line stays released, no commits.
        mdio_read(5'd3, 5'd24, 2, -1, got);
        mdio_write(5'd3, 5'd24, 16'hDEAD, 2'b10, 2);
        mdio_read(PHY, 5'd24, 0, -1, got);
        check("after_foreign", 32'(got), 32'h1357);

        // Bad turnaround on writes: frame skipped.
        mdio_write(PHY, 5'd24, 16'hCAFE, 2'b11, 2);
        mdio_write(PHY, 5'd3, 16'h0F0F, 2'b00, 1);
        mdio_read(PHY, 5'd24, 1, -1, got);
        check("bad_ta_reg24", 32'(got), 32'h1357);
        mdio_read(PHY, 5'd3, 0, -1, got);
        check("bad_ta_reg3", 32'(got), 32'hA5C3);

        // Out-of-range page: write acknowledged but dropped.
        mdio_write(PHY, 5'd22, 16'h0005, 2'b10, 2);
        mdio_write(PHY, 5'd24, 16'hBEEF, 2'b10, 0);
        mdio_read(PHY, 5'd24, 0, -1, got);
        check("p5_reg24", 32'(got), 32'h0000);
        mdio_read(PHY, 5'd22, 0, -1, got);
        check("p5_page_rd", 32'(got), 32'h0005);
        mdio_write(PHY, 5'd22, 16'h0000, 2'b10, 0);
        mdio_read(PHY, 5'd24, 0, -1, got);
        check("p0_reg24_kept", 32'(got), 32'h1357);

        // Stall mid-header, then a frame with no preamble must be decoded cleanly.
        preamble(4);
        send_bits(32'h0000_0506, 12);
        repeat (1100) @(posedge clk);
        #7;
        check("timeout_oe", 32'(dut.mdio_oe_q), 32'd0);
        mdio_write(PHY, 5'd24, 16'h4242, 2'b10, 0);
        mdio_read(PHY, 5'd24, 2, -1, got);
        check("after_timeout", 32'(got), 32'h4242);

        // Reset in the middle of a read's data phase.
        mdio_write(PHY, 5'd22, 16'h0002, 2'b10, 2);
        mdio_write(PHY, 5'd24, 16'h55AA, 2'b10, 0);
        mdio_read(PHY, 5'd24, 2, 7, got);
        mdio_read(PHY, 5'd22, 2, -1, got);
        check("post_rst_page", 32'(got), 32'h0000);
        mdio_read(PHY, 5'd24, 0, -1, got);
        check("post_rst_p0r24", 32'(got), 32'h0000);
        mdio_write(PHY, 5'd22, 16'h0002, 2'b10, 0);
        mdio_read(PHY, 5'd24, 0, -1, got);
        check("post_rst_p2r24", 32'(got), 32'h0000);

        repeat (20) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
